mips_prog_loader: RTL and testbench

//  Byte-stream program loader for the pipe_MIPS32 core: receives a framed image over an
//  8-bit valid/ready link and writes 32-bit words into the shared Mem array.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_prog_loader_if.sv | 34 +++
 rtl/loader_word_asm.sv | 44 ++++
 rtl/mips_prog_loader.sv | 162 ++++++++++++++++
 tb/tb_mips_prog_loader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the pipe_MIPS32 program loader: state encoding and frame constants.
package mips_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    // Length header is a 16-bit big-endian word count (LEN_HI, LEN_LO)
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned CSUM_W         = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

    // Running checksum is a plain XOR over every accepted header and data byte
    function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream receive link plus memory write port of the program loader.
interface mips_prog_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    import mips_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    // Host / byte source and memory observer side
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: collects four bytes, first byte in the MSBs.
module loader_word_asm
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

    logic [1:0]               cnt_q, cnt_d;
    logic [WORD_W-BYTE_W-1:0] sr_q, sr_d;

    // Word completes combinationally on the 4th byte so the top can register the write
    always_comb begin
        word_valid = byte_valid && (cnt_q == LastIdx);
        word       = {sr_q, byte_in};
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {sr_q[WORD_W-2*BYTE_W-1:0], byte_in};
        end
    end

    // Byte counter and shift register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader: writes words into Mem, holds the core until verified.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_prog_loader_if.slave   bus,
    input  logic                start,
    output logic                cpu_hold,
    output logic                cpu_start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     words_loaded
);

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_start_q, cpu_start_d;

    logic              in_frame;
    logic              accept;
    logic              start_fire;
    logic [LEN_W-1:0]  len_rx;
    logic              last_word;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign in_frame   = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign accept     = bus.rx_valid && in_frame;
    assign start_fire = start && ((state_q == StIdle) || (state_q == StDone) ||
                                  (state_q == StErr));
    assign len_rx     = {len_q[LEN_W-1:BYTE_W], bus.rx_data};
    assign last_word  = (32'(words_q) + 32'd1) == 32'(len_q);

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_fire),
        .byte_valid (accept && (state_q == StData)),
        .byte_in    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame FSM, checksum, word count and registered write port
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_start_d = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLenHi;
                    len_d   = '0;
                    csum_d  = '0;
                    words_d = '0;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[LEN_W-1:BYTE_W] = bus.rx_data;
                    csum_d                = csum_step(csum_q, bus.rx_data);
                    state_d               = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d  = len_rx;
                    csum_d = csum_step(csum_q, bus.rx_data);
                    if (len_rx == '0) begin
                        state_d = StCsum;
                    end else if (32'(len_rx) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_step(csum_q, bus.rx_data);
                    if (word_valid) begin
                        mem_we_d    = 1'b1;
                        // Address arithmetic wraps naturally at 2^ADDR_W
                        mem_addr_d  = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
                        mem_wdata_d = word;
                        words_d     = words_q + 1'b1;
                        if (last_word) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        state_d     = StDone;
                        cpu_start_d = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_start_q <= cpu_start_d;
        end
    end

    // Status outputs decode directly from state; hold releases only in DONE
    assign bus.rx_ready  = in_frame;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = in_frame;
    assign done          = (state_q == StDone);
    assign err           = (state_q == StErr);
    assign cpu_hold      = (state_q != StDone);
    assign cpu_start     = cpu_start_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: framed loads against a byte/word reference model.
module tb_mips_prog_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cpu_hold, cpu_start, busy, done, err;
    logic [AW:0]   words_loaded;

    mips_prog_loader_if #(.ADDR_W(AW)) lif ();

    mips_prog_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (0),
        .MAX_WORDS (1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (lif),
        .start        (start),
        .cpu_hold     (cpu_hold),
        .cpu_start    (cpu_start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;
    int          cs_cnt = 0;
    logic [31:0] tb_mem [0:1023];
    logic [31:0] word_q [$];
    logic [7:0]  frame_q [$];
    logic [31:0] prog [0:7] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

    // Observed memory image and pulse counts, sampled away from the rising edge
    always @(negedge clk) begin
        if (lif.mem_we === 1'b1) begin
            tb_mem[lif.mem_addr] = lif.mem_wdata;
            we_cnt++;
        end
        if (cpu_start === 1'b1) cs_cnt++;
    end

    // Reference frame: length header, big-endian words, XOR checksum (optionally corrupted)
    function automatic void build_frame(input bit bad);
        logic [15:0] n;
        logic [7:0]  cs;
        n = 16'(word_q.size());
        frame_q.delete();
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        foreach (word_q[i]) begin
            for (int b = 3; b >= 0; b--) frame_q.push_back(word_q[i][8*b +: 8]);
        end
        cs = 8'h00;
        foreach (frame_q[i]) cs = cs ^ frame_q[i];
        frame_q.push_back(bad ? (cs ^ 8'h01) : cs);
    endfunction

    function automatic void load_prog();
        word_q.delete();
        for (int i = 0; i < 8; i++) word_q.push_back(prog[i]);
    endfunction

    function automatic void clear_obs();
        for (int i = 0; i < 1024; i++) tb_mem[i] = 'x;
        we_cnt = 0;
        cs_cnt = 0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the byte is taken
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int tmo;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        lif.rx_data  = b;
        lif.rx_valid = 1'b1;
        tmo = 0;
        while (lif.rx_ready !== 1'b1 && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b want 1 within 50 cycles", lif.rx_ready);
        end
        @(negedge clk);
        lif.rx_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int max_gap);
        for (int i = from; i < to; i++) send_byte(frame_q[i], max_gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
        vectors++; if ({busy, done, err, cpu_start} !== 4'b0) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", {busy, done, err, cpu_start}); end
        vectors++; if (lif.rx_ready !== 1'b0 || lif.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_bus: got rdy=%b we=%b want 0 0", lif.rx_ready, lif.mem_we); end
        vectors++; if (lif.mem_addr !== '0 || lif.mem_wdata !== '0 || words_loaded !== '0) begin miscompares++; $display("FAIL rst_data: got addr=%h wdata=%h wl=%0d want 0", lif.mem_addr, lif.mem_wdata, words_loaded); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (lif.rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL idle_after_rst: got rdy=%b hold=%b want 0 1", lif.rx_ready, cpu_hold); end
    endtask

    task automatic test_program();
        load_prog();
        build_frame(1'b0);
        clear_obs();
        do_start();
        vectors++; if (busy !== 1'b1 || lif.rx_ready !== 1'b1) begin miscompares++; $display("FAIL prog_busy: got busy=%b rdy=%b want 1 1", busy, lif.rx_ready); end
        send_range(0, frame_q.size() - 1, 0);
        vectors++; if (lif.mem_we !== 1'b1 || lif.mem_addr !== 10'd7 || lif.mem_wdata !== 32'hfc000000) begin miscompares++; $display("FAIL prog_last_write: got we=%b addr=%0d wdata=%h want 1 7 fc000000", lif.mem_we, lif.mem_addr, lif.mem_wdata); end
        vectors++; if (cpu_start !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL prog_early_release: got start=%b hold=%b want 0 1", cpu_start, cpu_hold); end
        send_byte(frame_q[frame_q.size() - 1], 0);
        vectors++; if (cpu_start !== 1'b1 || cpu_hold !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL prog_release: got start=%b hold=%b done=%b want 1 0 1", cpu_start, cpu_hold, done); end
        settle();
        for (int k = 0; k < 8; k++) begin
            vectors++; if (tb_mem[k] !== prog[k]) begin miscompares++; $display("FAIL prog_mem[%0d]: got %h want %h", k, tb_mem[k], prog[k]); end
        end
        vectors++; if (words_loaded !== 11'd8 || we_cnt != 8 || cs_cnt != 1) begin miscompares++; $display("FAIL prog_counts: got wl=%0d we=%0d cs=%0d want 8 8 1", words_loaded, we_cnt, cs_cnt); end
        vectors++; if (cpu_start !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL prog_after: got start=%b busy=%b err=%b want 0 0 0", cpu_start, busy, err); end
    endtask

    task automatic test_restart();
        // Expects to enter in DONE
        do_start();
        vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== '0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart: got hold=%b done=%b wl=%0d busy=%b want 1 0 0 1", cpu_hold, done, words_loaded, busy); end
        vectors++; if (we_cnt != 8) begin miscompares++; $display("FAIL restart_no_write: got we=%0d want 8", we_cnt); end
        load_prog();
        build_frame(1'b0);
        send_range(0, frame_q.size(), 0);
        settle();
        vectors++; if (done !== 1'b1 || words_loaded !== 11'd8) begin miscompares++; $display("FAIL restart_reload: got done=%b wl=%0d want 1 8", done, words_loaded); end
    endtask

    task automatic test_bad_csum();
        load_prog();
        build_frame(1'b1);
        clear_obs();
        do_start();
        send_range(0, frame_q.size(), 0);
        vectors++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || cpu_start !== 1'b0) begin miscompares++; $display("FAIL bad_csum: got err=%b done=%b hold=%b start=%b want 1 0 1 0", err, done, cpu_hold, cpu_start); end
        settle();
        vectors++; if (cs_cnt != 0 || we_cnt != 8 || busy !== 1'b0) begin miscompares++; $display("FAIL bad_csum_counts: got cs=%0d we=%0d busy=%b want 0 8 0", cs_cnt, we_cnt, busy); end
    endtask

    task automatic test_lengths();
        clear_obs();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        vectors++; if (done !== 1'b1 || cpu_start !== 1'b1) begin miscompares++; $display("FAIL zero_len: got done=%b start=%b want 1 1", done, cpu_start); end
        settle();
        vectors++; if (we_cnt != 0 || words_loaded !== '0) begin miscompares++; $display("FAIL zero_len_writes: got we=%0d wl=%0d want 0 0", we_cnt, words_loaded); end
        do_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        vectors++; if (err !== 1'b1 || lif.rx_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin miscompares++; $display("FAIL over_len: got err=%b rdy=%b busy=%b hold=%b want 1 0 0 1", err, lif.rx_ready, busy, cpu_hold); end
        // Largest accepted image fills the whole address space exactly once
        word_q.delete();
        for (int i = 0; i < 1024; i++) word_q.push_back($urandom);
        build_frame(1'b0);
        clear_obs();
        do_start();
        send_range(0, frame_q.size(), 0);
        settle();
        vectors++; if (done !== 1'b1 || words_loaded !== 11'd1024 || we_cnt != 1024) begin miscompares++; $display("FAIL max_len: got done=%b wl=%0d we=%0d want 1 1024 1024", done, words_loaded, we_cnt); end
        vectors++; if (tb_mem[0] !== word_q[0] || tb_mem[1023] !== word_q[1023]) begin miscompares++; $display("FAIL max_len_mem: got %h %h want %h %h", tb_mem[0], tb_mem[1023], word_q[0], word_q[1023]); end
    endtask

    task automatic test_random_gaps();
        for (int rep = 0; rep < 5; rep++) begin
            bit bad;
            int n;
            int bad_words;
            word_q.delete();
            if (rep == 0) begin
                load_prog();
                bad = 1'b0;
            end else begin
                n = $urandom_range(1, 24);
                for (int i = 0; i < n; i++) word_q.push_back($urandom);
                bad = ($urandom_range(0, 3) == 0);
            end
            n = word_q.size();
            build_frame(bad);
            clear_obs();
            do_start();
            send_range(0, frame_q.size(), 5);
            settle();
            vectors++; if (done !== !bad || err !== bad || cpu_hold !== bad || cs_cnt != int'(!bad)) begin miscompares++; $display("FAIL gaps_result[%0d]: got done=%b err=%b hold=%b cs=%0d bad=%b", rep, done, err, cpu_hold, cs_cnt, bad); end
            vectors++; if (words_loaded !== 11'(n) || we_cnt != n) begin miscompares++; $display("FAIL gaps_count[%0d]: got wl=%0d we=%0d want %0d", rep, words_loaded, we_cnt, n); end
            bad_words = 0;
            for (int k = 0; k < n; k++) if (tb_mem[k] !== word_q[k]) bad_words++;
            vectors++; if (bad_words != 0) begin miscompares++; $display("FAIL gaps_mem[%0d]: got %0d wrong words want 0", rep, bad_words); end
        end
    endtask

    task automatic test_reset_mid();
        load_prog();
        build_frame(1'b0);
        clear_obs();
        do_start();
        send_range(0, 14, 0);
        vectors++; if (lif.mem_we !== 1'b1 || lif.mem_addr !== 10'd2) begin miscompares++; $display("FAIL mid_third_word: got we=%b addr=%0d want 1 2", lif.mem_we, lif.mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (cpu_hold !== 1'b1 || busy !== 1'b0 || lif.rx_ready !== 1'b0 || words_loaded !== '0) begin miscompares++; $display("FAIL mid_reset: got hold=%b busy=%b rdy=%b wl=%0d want 1 0 0 0", cpu_hold, busy, lif.rx_ready, words_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
        do_start();
        send_range(0, frame_q.size(), 2);
        settle();
        vectors++; if (done !== 1'b1 || words_loaded !== 11'd8 || tb_mem[0] !== prog[0] || tb_mem[7] !== prog[7]) begin miscompares++; $display("FAIL mid_reload: got done=%b wl=%0d m0=%h m7=%h", done, words_loaded, tb_mem[0], tb_mem[7]); end
    endtask

    task automatic test_start_in_data();
        word_q.delete();
        for (int i = 0; i < 4; i++) word_q.push_back($urandom);
        build_frame(1'b0);
        clear_obs();
        do_start();
        send_range(0, 7, 0);
        do_start();
        vectors++; if (busy !== 1'b1 || words_loaded !== 11'd1) begin miscompares++; $display("FAIL start_in_data: got busy=%b wl=%0d want 1 1", busy, words_loaded); end
        send_range(7, frame_q.size(), 0);
        settle();
        vectors++; if (done !== 1'b1 || words_loaded !== 11'd4 || tb_mem[1] !== word_q[1] || tb_mem[3] !== word_q[3]) begin miscompares++; $display("FAIL start_in_data_end: got done=%b wl=%0d m1=%h m3=%h", done, words_loaded, tb_mem[1], tb_mem[3]); end
    endtask

    initial begin
        lif.rx_data  = 8'h00;
        lif.rx_valid = 1'b0;
        test_reset();
        test_program();
        test_restart();
        test_bad_csum();
        test_lengths();
        test_random_gaps();
        test_reset_mid();
        test_start_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
